cmp_stim_checker: RTL

CMP_STIM_CHECKER -- requirements
Module: cmp_stim_checker

---
 rtl/cmp_stim_checker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cmp_stim_checker.sv
// rtl/cmp_stim_checker.sv - exhaustive operand sweep generator and result checker for a comparator
module cmp_stim_checker #(
   parameter int W   = 4,
   parameter int LAT = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   input  logic         y_i,
   input  logic         z_i,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [15:0]  err_cnt,
   output logic         ferr_vld,
   output logic [W-1:0] ferr_a,
   output logic [W-1:0] ferr_b
);

   localparam int N = 2 * W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [N-1:0]   r_cnt;
   logic [1:0]     r_dcnt;
   logic [15:0]    r_err;
   logic           r_fv;
   logic [W-1:0]   r_fa;
   logic [W-1:0]   r_fb;

   logic           w_last;
   logic           w_go;
   logic           w_busy;
   logic [W-1:0]   w_ca;
   logic [W-1:0]   w_cb;
   logic           w_cv;
   logic           w_exp_y;
   logic           w_mis;

   assign w_last = &r_cnt;
   assign w_busy = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_go   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // The pair being judged this edge: the live pair for a combinational
   // comparator, otherwise the oldest entry of the expected-value pipeline.
   generate
      if (LAT == 0) begin : g_nopipe
         assign w_ca = r_cnt[N-1:W];
         assign w_cb = r_cnt[W-1:0];
         assign w_cv = (r_state == S_RUN);
      end else begin : g_pipe
         logic [W-1:0] r_pa [LAT];
         logic [W-1:0] r_pb [LAT];
         logic         r_pv [LAT];

         // Shift driven pairs through LAT stages; bubbles enter during DRAIN,
         // and the whole pipe is flushed outside a sweep or on abort.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < LAT; i++) begin
                  r_pa[i] <= '0;
                  r_pb[i] <= '0;
                  r_pv[i] <= 1'b0;
               end
            end else if (!w_busy || abort) begin
               for (int i = 0; i < LAT; i++) r_pv[i] <= 1'b0;
            end else begin
               r_pa[0] <= r_cnt[N-1:W];
               r_pb[0] <= r_cnt[W-1:0];
               r_pv[0] <= (r_state == S_RUN);
               for (int i = 1; i < LAT; i++) begin
                  r_pa[i] <= r_pa[i-1];
                  r_pb[i] <= r_pb[i-1];
                  r_pv[i] <= r_pv[i-1];
               end
            end
         end

         assign w_ca = r_pa[LAT-1];
         assign w_cb = r_pb[LAT-1];
         assign w_cv = r_pv[LAT-1];
      end
   endgenerate

   assign w_exp_y = !(w_ca < w_cb);
   assign w_mis   = w_cv && ((y_i != w_exp_y) || (z_i != 1'b1));

   // Next-state selection; abort outranks start while a sweep is active.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN: begin
            if (abort)       w_next = S_IDLE;
            else if (w_last) w_next = (LAT == 0) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            if (abort)                          w_next = S_IDLE;
            else if (int'(r_dcnt) == LAT - 1)   w_next = S_DONE;
         end
         S_DONE:  if (start) w_next = S_RUN;
         default: w_next = S_IDLE;
      endcase
   end

   // State, pair counter, error counter and first-error capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dcnt  <= '0;
         r_err   <= '0;
         r_fv    <= 1'b0;
         r_fa    <= '0;
         r_fb    <= '0;
      end else begin
         r_state <= w_next;
         r_dcnt  <= (r_state == S_DRAIN) ? r_dcnt + 2'd1 : 2'd0;
         if (w_go) begin
            r_cnt <= '0;
            r_err <= '0;
            r_fv  <= 1'b0;
            r_fa  <= '0;
            r_fb  <= '0;
         end else begin
            if (w_mis) begin
               if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
               if (!r_fv) begin
                  r_fv <= 1'b1;
                  r_fa <= w_ca;
                  r_fb <= w_cb;
               end
            end
            // The last pair is held after the wrap so DRAIN/DONE keep driving it.
            if (w_busy && abort)
               r_cnt <= '0;
            else if ((r_state == S_RUN) && !w_last)
               r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign a_o      = r_cnt[N-1:W];
   assign b_o      = r_cnt[W-1:0];
   assign busy     = w_busy;
   assign done     = (r_state == S_DONE);
   assign pass     = done && (r_err == 16'd0);
   assign err_cnt  = r_err;
   assign ferr_vld = r_fv;
   assign ferr_a   = r_fa;
   assign ferr_b   = r_fb;

endmodule
